// File: rtl/uidbuf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uidbuf_pkg
//  Description : Shared definitions for the write-side buffer ring controller
//                (FSM state encoding, bytes-per-word constant).
//  Revision    : 1.0 - initial release
// ============================================================================
package uidbuf_pkg;

  // DDR word size used for all byte-address arithmetic
  localparam int BYTES_PER_WORD = 4;

  // Write controller FSM states, explicitly encoded
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_REQ   = 3'd2,
    ST_BURST = 3'd3,
    ST_NEXT  = 3'd4,
    ST_IRQ   = 3'd5
  } wctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/uidbuf_irqgen.sv
`default_nettype none
// ============================================================================
//  Module      : uidbuf_irqgen
//  Description : Stretches a single-cycle start strobe into an IRQ_CYC-cycle
//                high pulse, always followed by at least one low cycle. A
//                start arriving while busy is held and fired once free.
//  Revision    : 1.0 - initial release
// ============================================================================
module uidbuf_irqgen #(
  parameter int IRQ_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_irq,
  output logic o_done
);

  localparam int CW = (IRQ_CYC > 1) ? $clog2(IRQ_CYC) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_irq;
  logic          r_gap;
  logic          r_pend;
  logic          w_fire;

  // A new pulse may only start when neither high nor in the mandatory gap
  assign w_fire = (i_start | r_pend) & ~r_irq & ~r_gap;

  // Pulse counter, one-cycle low gap after each pulse, pending-start latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_irq  <= 1'b0;
      r_gap  <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_gap <= 1'b0;
      if (r_irq) begin
        if (r_cnt == '0) begin
          r_irq <= 1'b0;
          r_gap <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end else if (w_fire) begin
        r_irq <= 1'b1;
        r_cnt <= CW'(IRQ_CYC - 1);
      end
      if (w_fire) begin
        r_pend <= 1'b0;
      end else if (i_start) begin
        r_pend <= 1'b1;
      end
    end
  end

  assign o_irq  = r_irq;
  assign o_done = r_irq & (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uidbuf_wctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uidbuf_wctrl
//  Description : Write-side multi-buffer ring controller. Drains a FWFT FIFO
//                in fixed-length FDMA bursts into BUF_NUM back-to-back DDR
//                buffers and publishes each completed buffer index with an
//                IRQ_CYC-cycle completion pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module uidbuf_wctrl
  import uidbuf_pkg::*;
#(
  parameter int BUF_NUM   = 3,
  parameter int BUF_WORDS = 4096,
  parameter int BURST_LEN = 256,
  parameter int IRQ_CYC   = 4,
  parameter int CNT_W     = 12
) (
  input  logic             ui_clk,
  input  logic             ui_rst,
  input  logic             enable,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] fifo_cnt,
  input  logic [31:0]      fifo_dout,
  output logic             fifo_rd_en,
  output logic [31:0]      fdma_waddr,
  output logic [15:0]      fdma_wsize,
  output logic             fdma_wareq,
  input  logic             fdma_wbusy,
  input  logic             fdma_wvalid,
  output logic [31:0]      fdma_wdata,
  output logic [7:0]       fdma_wbuf,
  output logic             fdma_wirq,
  output logic             err
);

  // Reject geometries the ring arithmetic cannot represent
  generate
    if ((BURST_LEN < 1) || (BURST_LEN > 65535) || (BUF_NUM < 1) || (BUF_NUM > 255) ||
        (IRQ_CYC < 1) || ((BUF_WORDS % BURST_LEN) != 0)) begin : g_bad_param
      $error("uidbuf_wctrl: illegal parameter set (BUF_WORDS must be a multiple of BURST_LEN)");
    end
  endgenerate

  localparam logic [31:0] c_burst_words = 32'(BURST_LEN);
  localparam logic [31:0] c_buf_words   = 32'(BUF_WORDS);
  localparam logic [31:0] c_buf_bytes   = 32'(BUF_WORDS * BYTES_PER_WORD);
  localparam logic [31:0] c_word_bytes  = 32'(BYTES_PER_WORD);
  localparam logic [7:0]  c_last_buf    = 8'(BUF_NUM - 1);
  localparam logic [16:0] c_burst_beats = 17'(BURST_LEN);

  wctrl_state_e r_state;
  wctrl_state_e w_state_nxt;

  logic        r_en_d;
  logic [31:0] r_base;
  logic [7:0]  r_buf_idx;
  logic [31:0] r_offset;
  logic [31:0] r_waddr;
  logic [16:0] r_beat;
  logic [7:0]  r_wbuf;
  logic        r_err;

  logic        w_en_rise;
  logic        w_start_burst;
  logic [31:0] w_offset_nxt;
  logic        w_buf_done;
  logic [16:0] w_beat_final;
  logic        w_burst_end;
  logic        w_irq_start;
  logic        w_irq_done;
  logic [31:0] w_addr;
  logic        w_wareq;
  logic        w_rd_en;

  assign w_en_rise     = enable & ~r_en_d;
  assign w_start_burst = (r_state == ST_WAIT) && enable &&
                         (32'(fifo_cnt) >= c_burst_words) && !fdma_wbusy;
  assign w_offset_nxt  = r_offset + c_burst_words;
  assign w_buf_done    = (w_offset_nxt >= c_buf_words);
  // Beat total including a valid that coincides with the busy fall
  assign w_beat_final  = r_beat + 17'(fdma_wvalid);
  assign w_burst_end   = (r_state == ST_BURST) && !fdma_wbusy;
  assign w_irq_start   = (r_state == ST_NEXT) && w_buf_done;
  assign w_addr        = r_base + (32'(r_buf_idx) * c_buf_bytes) + (r_offset * c_word_bytes);

  // Completion pulse generator
  uidbuf_irqgen #(
    .IRQ_CYC (IRQ_CYC)
  ) u_irqgen (
    .clk     (ui_clk),
    .rst     (ui_rst),
    .i_start (w_irq_start),
    .o_irq   (fdma_wirq),
    .o_done  (w_irq_done)
  );

  // FSM state register
  always_ff @(posedge ui_clk) begin
    if (ui_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and state-decoded handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_wareq     = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_en_rise) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!enable)            w_state_nxt = ST_IDLE;
        else if (w_start_burst) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        w_wareq = 1'b1;
        if (fdma_wbusy) w_state_nxt = ST_BURST;
      end
      ST_BURST: begin
        w_rd_en = fdma_wvalid;
        if (!fdma_wbusy) w_state_nxt = ST_NEXT;
      end
      ST_NEXT: begin
        w_state_nxt = w_buf_done ? ST_IRQ : ST_WAIT;
      end
      ST_IRQ: begin
        if (w_irq_done) w_state_nxt = ST_WAIT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Ring position, burst address, beat count, completed index and error flag
  always_ff @(posedge ui_clk) begin
    if (ui_rst) begin
      r_en_d    <= 1'b0;
      r_base    <= '0;
      r_buf_idx <= '0;
      r_offset  <= '0;
      r_waddr   <= '0;
      r_beat    <= '0;
      r_wbuf    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_en_d <= enable;
      if ((r_state == ST_IDLE) && w_en_rise) begin
        r_base    <= base_addr;
        r_buf_idx <= '0;
        r_offset  <= '0;
      end
      if (w_start_burst) begin
        r_waddr <= w_addr;
      end
      if (r_state == ST_REQ) begin
        r_beat <= '0;
      end else if ((r_state == ST_BURST) && fdma_wvalid && (r_beat != '1)) begin
        r_beat <= r_beat + 1'b1;
      end
      if (w_burst_end && (w_beat_final != c_burst_beats)) begin
        r_err <= 1'b1;
      end
      if (r_state == ST_NEXT) begin
        if (w_buf_done) begin
          r_offset  <= '0;
          r_wbuf    <= r_buf_idx;
          r_buf_idx <= (r_buf_idx == c_last_buf) ? 8'd0 : r_buf_idx + 8'd1;
        end else begin
          r_offset <= w_offset_nxt;
        end
      end
    end
  end

  assign fdma_wareq = w_wareq;
  assign fifo_rd_en = w_rd_en;
  assign fdma_waddr = r_waddr;
  assign fdma_wsize = 16'(BURST_LEN);
  assign fdma_wdata = fifo_dout;
  assign fdma_wbuf  = r_wbuf;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uidbuf_wctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uidbuf_wctrl
//  Description : Self-checking bench for uidbuf_wctrl with a randomized FDMA
//                responder, an always-ready FIFO source and a ring-position
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uidbuf_wctrl;

  localparam int BUF_NUM     = 3;
  localparam int BUF_WORDS   = 512;
  localparam int BURST_LEN   = 256;
  localparam int IRQ_CYC     = 4;
  localparam int CNT_W       = 12;
  localparam int RING_BURSTS = BUF_NUM * BUF_WORDS / BURST_LEN;
  localparam int BURST_BYTES = BURST_LEN * 4;

  logic             clk;
  logic             ui_rst;
  logic             enable;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] fifo_cnt;
  logic [31:0]      fifo_dout;
  logic             fifo_rd_en;
  logic [31:0]      fdma_waddr;
  logic [15:0]      fdma_wsize;
  logic             fdma_wareq;
  logic             fdma_wbusy;
  logic             fdma_wvalid;
  logic [31:0]      fdma_wdata;
  logic [7:0]       fdma_wbuf;
  logic             fdma_wirq;
  logic             err;

  uidbuf_wctrl #(
    .BUF_NUM   (BUF_NUM),
    .BUF_WORDS (BUF_WORDS),
    .BURST_LEN (BURST_LEN),
    .IRQ_CYC   (IRQ_CYC),
    .CNT_W     (CNT_W)
  ) dut (
    .ui_clk      (clk),
    .ui_rst      (ui_rst),
    .enable      (enable),
    .base_addr   (base_addr),
    .fifo_cnt    (fifo_cnt),
    .fifo_dout   (fifo_dout),
    .fifo_rd_en  (fifo_rd_en),
    .fdma_waddr  (fdma_waddr),
    .fdma_wsize  (fdma_wsize),
    .fdma_wareq  (fdma_wareq),
    .fdma_wbusy  (fdma_wbusy),
    .fdma_wvalid (fdma_wvalid),
    .fdma_wdata  (fdma_wdata),
    .fdma_wbuf   (fdma_wbuf),
    .fdma_wirq   (fdma_wirq),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: bursts requested and buffers completed since the
  // last ring restart, plus the base latched at that restart.
  int          mdl_burst = 0;
  int          mdl_irq   = 0;
  logic [31:0] mdl_base  = 32'h0;
  int          n_req     = 0;
  int          cyc       = 0;
  int          fall_cyc  = 0;
  bit          short_next = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic restart_model(input logic [31:0] base);
    mdl_base  = base;
    mdl_burst = 0;
    mdl_irq   = 0;
  endtask

  task automatic wait_irqs(input int n, input int budget);
    int k = 0;
    while (mdl_irq < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_irq", 32'(mdl_irq >= n), 32'd1);
  endtask

  task automatic wait_busy(input logic lvl, input int budget);
    int k = 0;
    while (fdma_wbusy !== lvl && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_busy", 32'(fdma_wbusy), 32'(lvl));
  endtask

  // FDMA responder and FIFO source: accepts each request after a random
  // delay, streams BURST_LEN (or one short) beats with random gaps.
  initial begin : fdma_model
    int n;
    int cnt;
    fdma_wbusy  = 1'b0;
    fdma_wvalid = 1'b0;
    fifo_dout   = 32'hA5A5_0000;
    forever begin
      @(negedge clk);
      if (ui_rst) begin
        fdma_wbusy  = 1'b0;
        fdma_wvalid = 1'b0;
      end else if (fdma_wareq) begin
        fdma_wvalid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        fdma_wbusy = 1'b1;
        n          = short_next ? BURST_LEN - 1 : BURST_LEN;
        short_next = 1'b0;
        cnt        = 0;
        @(negedge clk);
        while (cnt < n) begin
          fdma_wvalid = ($urandom_range(0, 3) != 0);
          #1;
          chk("rd_en", 32'(fifo_rd_en), 32'(fdma_wvalid));
          if (fdma_wvalid) chk("wdata", fdma_wdata, fifo_dout);
          @(negedge clk);
          if (fdma_wvalid) begin
            cnt++;
            fifo_dout = fifo_dout + 32'h9E37_79B9;
          end
        end
        fdma_wvalid = 1'b0;
        fdma_wbusy  = 1'b0;
        fall_cyc    = cyc;
      end else begin
        fdma_wvalid = ($urandom_range(0, 7) == 0);
        #1;
        if (fdma_wvalid) chk("stray_pop", 32'(fifo_rd_en), 32'd0);
      end
    end
  end

  // Output monitor: burst addresses, completion index, pulse shape, latency
  initial begin : monitor
    logic       prev_wareq = 1'b0;
    logic       prev_wirq  = 1'b0;
    int         irq_hi     = 0;
    logic [7:0] wbuf_seen  = 8'h0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (!ui_rst) begin
        if (fdma_wareq && !prev_wareq) begin
          chk("waddr", fdma_waddr,
              mdl_base + 32'((mdl_burst % RING_BURSTS) * BURST_BYTES));
          mdl_burst++;
          n_req++;
        end
        if (fdma_wirq && !prev_wirq) begin
          chk("wbuf", 32'(fdma_wbuf), 32'(mdl_irq % BUF_NUM));
          chk("irq_latency", 32'(cyc - fall_cyc), 32'd2);
          mdl_irq++;
          irq_hi    = 1;
          wbuf_seen = fdma_wbuf;
        end else if (fdma_wirq) begin
          irq_hi++;
        end
        if (!fdma_wirq && prev_wirq) begin
          chk("irq_len", 32'(irq_hi), 32'(IRQ_CYC));
          chk("wbuf_hold", 32'(fdma_wbuf), 32'(wbuf_seen));
        end
      end
      prev_wareq = fdma_wareq;
      prev_wirq  = fdma_wirq;
    end
  end

  initial begin : main
    int snap_req;
    int snap_irq;
    int k;
    ui_rst    = 1'b1;
    enable    = 1'b0;
    base_addr = 32'h1000_0000;
    fifo_cnt  = CNT_W'(4095);
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_wareq", 32'(fdma_wareq), 32'd0);
    chk("rst_waddr", fdma_waddr, 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_wbuf", 32'(fdma_wbuf), 32'd0);
    chk("rst_wirq", 32'(fdma_wirq), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("wsize", 32'(fdma_wsize), 32'(BURST_LEN));
    @(negedge clk);
    ui_rst = 1'b0;
    @(negedge clk);

    // Full-FIFO ring: addresses wrap after RING_BURSTS, wbuf 0,1,2,0
    restart_model(32'h1000_0000);
    enable = 1'b1;
    wait_irqs(4, 8000);
    chk("err_clean", 32'(err), 32'd0);

    // FIFO below one burst stalls requests; one more word releases them
    wait_busy(1'b1, 1000);
    fifo_cnt = CNT_W'(BURST_LEN - 1);
    snap_req = n_req;
    wait_busy(1'b0, 1000);
    repeat (40) @(negedge clk);
    chk("starve_req", 32'(n_req - snap_req), 32'd0);
    chk("starve_wareq", 32'(fdma_wareq), 32'd0);
    fifo_cnt = CNT_W'(BURST_LEN);
    repeat (3) @(negedge clk);
    chk("release_req", 32'(n_req - snap_req), 32'd1);
    fifo_cnt = CNT_W'(4095);

    // Short burst sets sticky err; ring keeps going
    short_next = 1'b1;
    snap_req   = mdl_burst;
    k = 0;
    while (mdl_burst < snap_req + 2 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_short", 32'(mdl_burst >= snap_req + 2), 32'd1);
    chk("err_short", 32'(err), 32'd1);

    // Drop enable during the last burst of buffer 1
    k = 0;
    while (!((mdl_burst % RING_BURSTS) == 4 && fdma_wbusy) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_buf1", 32'(fdma_wbusy), 32'd1);
    enable   = 1'b0;
    snap_req = n_req;
    snap_irq = mdl_irq;
    repeat (700) @(negedge clk);
    chk("dis_no_req", 32'(n_req - snap_req), 32'd0);
    chk("dis_irq_done", 32'(mdl_irq - snap_irq), 32'd1);
    chk("dis_wbuf", 32'(fdma_wbuf), 32'd1);
    chk("err_sticky", 32'(err), 32'd1);

    // Re-enable restarts at buffer 0 with a freshly latched base
    base_addr = 32'h3000_0040;
    restart_model(32'h3000_0040);
    enable = 1'b1;
    wait_irqs(2, 5000);
    @(negedge clk);
    chk("pre_rst_wirq", 32'(fdma_wirq), 32'd1);
    chk("pre_rst_err", 32'(err), 32'd1);

    // Reset during IRQ: every output back to its reset value next cycle
    ui_rst = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #2;
    chk("irqrst_wareq", 32'(fdma_wareq), 32'd0);
    chk("irqrst_waddr", fdma_waddr, 32'd0);
    chk("irqrst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("irqrst_wbuf", 32'(fdma_wbuf), 32'd0);
    chk("irqrst_wirq", 32'(fdma_wirq), 32'd0);
    chk("irqrst_err", 32'(err), 32'd0);
    @(negedge clk);
    ui_rst = 1'b0;
    repeat (2) @(negedge clk);

    // Address arithmetic wraps through 2^32
    base_addr = 32'hFFFF_F800;
    restart_model(32'hFFFF_F800);
    enable = 1'b1;
    wait_irqs(2, 5000);
    chk("err_final", 32'(err), 32'd0);

    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
